// File: rtl/if_bpu.sv
// if_bpu: fetch-stage dynamic branch predictor.
// Pre-decodes B-type instructions, predicts direction from a table of 2-bit
// saturating counters and forms the target pc + sext(B-imm). The table is
// trained by the execute stage when a branch resolves.
// After reset the table is walked once, one entry per cycle, to weakly
// not-taken (2'b01); predictions are suppressed while that walk runs.
// Optional build macro: BPU_GSHARE_EN -- XOR a global history register into
// the table index (gshare). Undefined by default: indexing is pc-only.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | writing bht[init_idx] = 2'b01, one entry per cycle; busy
// ST_RUN  | predicting from the table, training on ex_branch

module if_bpu #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int GHR_BITS    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            ex_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    output logic            bpu_busy,
    output logic            pred_valid,
    output logic            pred_take,
    output logic [XLEN-1:0] pred_addr
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [IDX-1:0] LAST_IDX = IDX'(BHT_ENTRIES - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [IDX-1:0]  init_idx;
    logic            busy_q;
    logic [1:0]      bht [BHT_ENTRIES];

    logic [IDX-1:0]  rd_idx;
    logic [IDX-1:0]  wr_idx;
    logic [1:0]      ctr_cur;
    logic [1:0]      ctr_next;
    logic            is_btype;
    logic [12:0]     b_imm;

`ifdef BPU_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // Global history: shifted only by resolved branches in RUN, so a write
    // indexes with the history seen before its own outcome is appended.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (state == ST_RUN && ex_branch) begin
            ghr <= {ghr[GHR_BITS-2:0], ex_taken};
        end
    end

    assign rd_idx = if_pc[IDX+1:2] ^ IDX'(ghr);
    assign wr_idx = ex_pc[IDX+1:2] ^ IDX'(ghr);
`else
    assign rd_idx = if_pc[IDX+1:2];
    assign wr_idx = ex_pc[IDX+1:2];
`endif

    // Init/run sequencer; bpu_busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            busy_q   <= 1'b1;
        end else begin
            unique case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == LAST_IDX) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_INIT;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bpu_busy = busy_q;

    // Saturating counter step for the entry being trained.
    always_comb begin
        ctr_cur  = bht[wr_idx];
        ctr_next = ctr_cur;
        if (ex_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
        end
    end

    // Counter table: init walk, then training. Reads are combinational and
    // see the pre-update value when the same entry is written this cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                bht[init_idx] <= 2'b01;
            end else if (ex_branch) begin
                bht[wr_idx] <= ctr_next;
            end
        end
    end

    // Pre-decode, direction and target.
    always_comb begin
        is_btype   = (if_inst[6:0] == 7'b1100011);
        b_imm      = {if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
        pred_valid = if_valid & is_btype & (state == ST_RUN);
        pred_take  = pred_valid & bht[rd_idx][1];
        pred_addr  = if_pc + {{(XLEN-13){b_imm[12]}}, b_imm};
    end

    // Register fields and pc bits outside the index range carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, if_inst[24:12], ex_pc[1:0], ex_pc[XLEN-1:IDX+2]};

endmodule

// File: tb/tb_if_bpu.sv
// Directed bench for if_bpu: reset/init timing, a vector table of fetches
// against an untrained table, then hand sequences for training, saturation,
// same-cycle read/write, aliasing and re-initialisation.

module tb_if_bpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        bpu_busy;
    logic        pred_valid;
    logic        pred_take;
    logic [31:0] pred_addr;

    int checks = 0;
    int errors = 0;

    if_bpu dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .ex_branch  (ex_branch),
        .ex_pc      (ex_pc),
        .ex_taken   (ex_taken),
        .bpu_busy   (bpu_busy),
        .pred_valid (pred_valid),
        .pred_take  (pred_take),
        .pred_addr  (pred_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exp_valid;
        logic        exp_take;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive a beq fetch at pc and compare the prediction direction.
    task automatic probe(input string name, input logic [31:0] pc, input logic exp_take);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = enc_b(13'd16, 3'd0);
        #1;
        check(name, {31'd0, pred_take}, {31'd0, exp_take});
    endtask

    // One resolved branch in EX, returns on the following negedge.
    task automatic ex_pulse(input logic [31:0] pc, input logic taken);
        @(negedge clk);
        ex_branch = 1'b1;
        ex_pc     = pc;
        ex_taken  = taken;
        @(negedge clk);
        ex_branch = 1'b0;
    endtask

    // Pulse rst for one edge, then count the cycles bpu_busy stays high.
    // With poke set, two taken updates to pc 0x40 are driven mid-init.
    task automatic reset_and_init(input string name, input bit poke);
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({name, "_busy_after_rst"}, {31'd0, bpu_busy}, 32'd1);
        check({name, "_pvalid_in_init"}, {31'd0, pred_valid}, 32'd0);
        check({name, "_ptake_in_init"}, {31'd0, pred_take}, 32'd0);
        n = 0;
        while (bpu_busy && n < 200) begin
            n++;
            if (poke && (n == 40 || n == 41)) begin
                ex_branch = 1'b1;
                ex_pc     = 32'h40;
                ex_taken  = 1'b1;
            end else begin
                ex_branch = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        ex_branch = 1'b0;
        check({name, "_init_cycles"}, n, 32'd64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"beq_fwd",     1'b1, 32'h0000_0100, enc_b(13'h0010, 3'd0), 1'b1, 1'b0, 32'h0000_0110};
        vecs[1] = '{"bne_back",    1'b1, 32'h0000_0200, enc_b(13'h1FF8, 3'd1), 1'b1, 1'b0, 32'h0000_01F8};
        vecs[2] = '{"addi_nop",    1'b1, 32'h0000_0200, 32'h0000_0013,         1'b0, 1'b0, 32'h0};
        vecs[3] = '{"no_ifvalid",  1'b0, 32'h0000_0100, enc_b(13'h0010, 3'd0), 1'b0, 1'b0, 32'h0};
        vecs[4] = '{"blt_wrap",    1'b1, 32'hFFFF_FFF0, enc_b(13'h0020, 3'd4), 1'b1, 1'b0, 32'h0000_0010};
        vecs[5] = '{"bge_min_imm", 1'b1, 32'h0000_0004, enc_b(13'h1000, 3'd5), 1'b1, 1'b0, 32'hFFFF_F004};
        vecs[6] = '{"bltu_max",    1'b1, 32'h0000_1000, enc_b(13'h0FFE, 3'd6), 1'b1, 1'b0, 32'h0000_1FFE};
        vecs[7] = '{"jal",         1'b1, 32'h0000_0100, 32'h0100_006F,         1'b0, 1'b0, 32'h0};

        rst       = 1'b1;
        if_valid  = 1'b1;
        if_pc     = 32'h100;
        if_inst   = enc_b(13'd16, 3'd0);
        ex_branch = 1'b0;
        ex_pc     = 32'h0;
        ex_taken  = 1'b0;
        repeat (2) @(negedge clk);

        reset_and_init("rst1", 1'b0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if_valid = vecs[i].v;
            if_pc    = vecs[i].pc;
            if_inst  = vecs[i].inst;
            #1;
            check({vecs[i].name, "_valid"}, {31'd0, pred_valid}, {31'd0, vecs[i].exp_valid});
            check({vecs[i].name, "_take"}, {31'd0, pred_take}, {31'd0, vecs[i].exp_take});
            if (vecs[i].exp_valid)
                check({vecs[i].name, "_addr"}, pred_addr, vecs[i].exp_addr);
        end

`ifdef BPU_GSHARE_EN
        // ghr=0 while training index 0; afterwards ghr=000001.
        ex_pulse(32'h100, 1'b1);
        probe("gs_pc100_reads_idx1", 32'h100, 1'b0);
        probe("gs_pc104_reads_idx0", 32'h104, 1'b1);
        reset_and_init("rst2", 1'b0);
        probe("gs_after_reinit", 32'h100, 1'b0);
        probe("gs_after_reinit_104", 32'h104, 1'b0);
`else
        // 01 -> 10 -> 11 -> 11 (saturate) -> 10 -> 01 -> 00 -> 00 (saturate) -> 01
        ex_pulse(32'h100, 1'b1);
        probe("train_t1", 32'h100, 1'b1);
        ex_pulse(32'h100, 1'b1);
        probe("train_t2", 32'h100, 1'b1);
        ex_pulse(32'h100, 1'b1);
        probe("train_t3_sat", 32'h100, 1'b1);
        ex_pulse(32'h100, 1'b0);
        probe("train_n1", 32'h100, 1'b1);
        ex_pulse(32'h100, 1'b0);
        probe("train_n2", 32'h100, 1'b0);
        ex_pulse(32'h100, 1'b0);
        probe("train_n3", 32'h100, 1'b0);
        ex_pulse(32'h100, 1'b0);
        probe("train_n4_sat", 32'h100, 1'b0);
        ex_pulse(32'h100, 1'b1);
        probe("train_t_after_floor", 32'h100, 1'b0);

        // Same-cycle update and fetch of pc 0x40 (index 0x10, counter 01).
        @(negedge clk);
        ex_branch = 1'b1;
        ex_pc     = 32'h40;
        ex_taken  = 1'b1;
        probe("same_cycle_pre", 32'h40, 1'b0);
        @(negedge clk);
        ex_branch = 1'b0;
        probe("same_cycle_post", 32'h40, 1'b1);
        probe("alias_pc140", 32'h140, 1'b1);
        probe("other_idx_pc44", 32'h44, 1'b0);

        // Mid-run reset, with updates to index 0x10 attempted during init.
        reset_and_init("rst2", 1'b1);
        probe("reinit_pc40", 32'h40, 1'b0);
        ex_pulse(32'h40, 1'b1);
        probe("reinit_pc40_t1", 32'h40, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
